// File: rtl/pc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pc_sequencer: fetch/advance/redirect/halt sequencer driving a PC select.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pc_sequencer #(
  parameter logic [29:0] TRAP_VECTOR = 30'h0000_0100,
  parameter int          CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic             br_valid,
  output logic             br_ready,
  input  logic             br_abs,
  input  logic [29:0]      br_target,
  input  logic             trap_req,
  input  logic             halt_req,
  output logic [1:0]       PS,
  output logic [29:0]      pc_in,
  output logic [CNT_W-1:0] fetch_count,
  output logic             halted
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FETCH    = 3'd1;
  localparam logic [2:0] S_ADVANCE  = 3'd2;
  localparam logic [2:0] S_REDIRECT = 3'd3;
  localparam logic [2:0] S_HALT     = 3'd4;

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic             r_boot;
  logic             r_buf_full;
  logic             r_buf_abs;
  logic [29:0]      r_buf_tgt;
  logic [CNT_W-1:0] r_fetch_count;
  logic             w_br_take;
  logic             w_full_after_cap;

  assign w_br_take        = br_valid & ~r_buf_full;
  assign w_full_after_cap = r_buf_full | trap_req | br_valid;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // IDLE spans one full cycle after reset release, so the first request rises on the second edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_boot <= 1'b0;
    end else begin
      r_boot <= 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (r_boot) w_state_nxt = S_FETCH;
      S_FETCH:    if (imem_ack) w_state_nxt = w_full_after_cap ? S_REDIRECT : S_ADVANCE;
      S_ADVANCE:  w_state_nxt = halt_req ? S_HALT : S_FETCH;
      S_REDIRECT: w_state_nxt = halt_req ? S_HALT : S_FETCH;
      S_HALT:     if (!halt_req) w_state_nxt = r_buf_full ? S_REDIRECT : S_FETCH;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  // Trap overrides everything, including the clear performed while the entry is being applied.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_buf_full <= 1'b0;
      r_buf_abs  <= 1'b0;
      r_buf_tgt  <= '0;
    end else if (trap_req) begin
      r_buf_full <= 1'b1;
      r_buf_abs  <= 1'b1;
      r_buf_tgt  <= TRAP_VECTOR;
    end else if (r_state == S_REDIRECT) begin
      r_buf_full <= 1'b0;
    end else if (w_br_take) begin
      r_buf_full <= 1'b1;
      r_buf_abs  <= br_abs;
      r_buf_tgt  <= br_target;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_fetch_count <= '0;
    end else if ((r_state == S_FETCH) && imem_ack) begin
      r_fetch_count <= r_fetch_count + CNT_W'(1);
    end
  end

  always_comb begin
    PS       = 2'b00;
    pc_in    = '0;
    imem_req = 1'b0;
    halted   = 1'b0;
    case (r_state)
      S_FETCH:    imem_req = 1'b1;
      S_ADVANCE:  PS = 2'b01;
      S_REDIRECT: begin
        PS    = r_buf_abs ? 2'b11 : 2'b10;
        pc_in = r_buf_tgt;
      end
      S_HALT:     halted = 1'b1;
      default:    ;
    endcase
  end

  assign br_ready    = ~r_buf_full;
  assign fetch_count = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pc_sequencer: scoreboard bench with a transaction-level PC model.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_pc_sequencer;
  localparam int          CNT_W = 4;
  localparam logic [29:0] TRAP  = 30'h0000_0100;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             imem_req, imem_ack, br_valid, br_ready, br_abs;
  logic [29:0]      br_target;
  logic             trap_req, halt_req, halted;
  logic [1:0]       PS;
  logic [29:0]      pc_in;
  logic [CNT_W-1:0] fetch_count;

  pc_sequencer #(.TRAP_VECTOR(TRAP), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .imem_req(imem_req), .imem_ack(imem_ack),
    .br_valid(br_valid), .br_ready(br_ready), .br_abs(br_abs), .br_target(br_target),
    .trap_req(trap_req), .halt_req(halt_req), .PS(PS), .pc_in(pc_in),
    .fetch_count(fetch_count), .halted(halted)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [1:0]  ps;
    logic [29:0] pcin;
    logic [31:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_fetch  = 0;
  logic [31:0] pc_model = 32'h8000_0000;
  logic [31:0] pc_mon   = 32'h8000_0000;
  bit          m_full   = 1'b0;
  bit          m_abs    = 1'b0;
  logic [29:0] m_tgt    = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every PC update the DUT presents is matched against the next expected one.
  exp_t e;
  always @(negedge clock) begin
    if (reset) begin
      if (PS != 2'b00) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_update: got PS=%b pc_in=%h expected no update", PS, pc_in);
        end else begin
          e = exp_q.pop_front();
          check("PS", 32'(PS), 32'(e.ps));
          check("pc_in", 32'(pc_in), 32'(e.pcin));
          case (PS)
            2'b01:   pc_mon = pc_mon + 32'd4;
            2'b10:   pc_mon = pc_mon + 32'd4 + {pc_in, 2'b00};
            default: pc_mon = {2'b00, pc_in};
          endcase
          check("pc", pc_mon, e.pc);
        end
      end else begin
        check("pc_in_idle", 32'(pc_in), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // The pending redirect (if any) is consumed by the next PC update, else PC steps by one word.
  task automatic push_update();
    exp_t x;
    if (m_full) begin
      x.ps   = m_abs ? 2'b11 : 2'b10;
      x.pcin = m_tgt;
      x.pc   = m_abs ? {2'b00, m_tgt} : pc_model + 32'd4 + 32'(m_tgt) * 32'd4;
      m_full = 1'b0;
    end else begin
      x.ps   = 2'b01;
      x.pcin = '0;
      x.pc   = pc_model + 32'd4;
    end
    pc_model = x.pc;
    exp_q.push_back(x);
  endtask

  task automatic drive_cycle(input bit ack, input bit br, input bit abs_i,
                             input logic [29:0] tgt, input bit trap);
    imem_ack  = ack;
    br_valid  = br;
    br_abs    = abs_i;
    br_target = tgt;
    trap_req  = trap;
    if (br) check("br_ready", 32'(br_ready), 32'(!m_full));
    if (trap) begin
      m_full = 1'b1; m_abs = 1'b1; m_tgt = TRAP;
    end else if (br && !m_full) begin
      m_full = 1'b1; m_abs = abs_i; m_tgt = tgt;
    end
    if (ack) begin
      n_fetch++;
      push_update();
    end
    tick();
    imem_ack = 1'b0; br_valid = 1'b0; trap_req = 1'b0;
  endtask

  task automatic wait_fetch(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL fetch_timeout: got imem_req=0 expected 1 within 20 cycles");
    end
  endtask

  task automatic do_fetch(input int waits, input bit halt, input int pbr,
                          input int ptrap, input bit halt_trap);
    bit ok;
    wait_fetch(ok);
    if (!ok) return;
    halt_req = halt;
    for (int i = 0; i <= waits; i++)
      drive_cycle(i == waits, ($urandom % 100) < pbr, $urandom % 2,
                  30'($urandom), ($urandom % 100) < ptrap);
    if (halt) begin
      tick();
      check("halted", 32'(halted), 32'd1);
      check("halt_imem_req", 32'(imem_req), 32'd0);
      check("halt_PS", 32'(PS), 32'd0);
      if (halt_trap) begin
        trap_req = 1'b1;
        m_full = 1'b1; m_abs = 1'b1; m_tgt = TRAP;
        tick();
        trap_req = 1'b0;
      end
      halt_req = 1'b0;
      if (m_full) push_update();
      tick();
      check("unhalted", 32'(halted), 32'd0);
      if (!halt_trap) check("resume_fetch", 32'(imem_req), 32'd1);
    end
  endtask

  initial begin
    bit ok;
    imem_ack = 0; br_valid = 0; br_abs = 0; br_target = '0; trap_req = 0; halt_req = 0;
    #3;
    check("rst_imem_req", 32'(imem_req), 32'd0);
    check("rst_PS", 32'(PS), 32'd0);
    check("rst_pc_in", 32'(pc_in), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_br_ready", 32'(br_ready), 32'd1);
    check("rst_fetch_count", 32'(fetch_count), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    check("boot_edge1_req", 32'(imem_req), 32'd0);
    tick();
    check("boot_edge2_req", 32'(imem_req), 32'd1);

    // Relative branch taken from reset PC, then trap beating a same-cycle branch.
    wait_fetch(ok);
    drive_cycle(0, 1, 0, 30'd3, 0);
    drive_cycle(1, 0, 0, '0, 0);
    wait_fetch(ok);
    drive_cycle(0, 1, 1, 30'h55, 1);
    drive_cycle(0, 1, 1, 30'h77, 0);
    drive_cycle(1, 0, 0, '0, 0);
    do_fetch(1, 1'b1, 0, 0, 1'b0);
    for (int k = 0; k < 4; k++) do_fetch(1, 1'b0, 0, 0, 1'b0);

    for (int k = 0; k < 40; k++)
      do_fetch($urandom_range(0, 3), ($urandom % 100) < 20, 30, 10, $urandom % 2);
    repeat (4) tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("fetch_count_wrap", 32'(fetch_count), 32'(n_fetch % 16));

    // Asynchronous reset in the middle of a fetch; a stray ack while idle must be ignored.
    wait_fetch(ok);
    #2;
    reset = 1'b0;
    #1;
    check("arst_imem_req", 32'(imem_req), 32'd0);
    check("arst_PS", 32'(PS), 32'd0);
    check("arst_fetch_count", 32'(fetch_count), 32'd0);
    check("arst_br_ready", 32'(br_ready), 32'd1);
    exp_q.delete();
    m_full = 1'b0;
    n_fetch = 0;
    #2;
    reset = 1'b1;
    imem_ack = 1'b1;
    tick();
    check("rel_edge1_req", 32'(imem_req), 32'd0);
    tick();
    imem_ack = 1'b0;
    check("rel_edge2_req", 32'(imem_req), 32'd1);
    check("stray_ack_count", 32'(fetch_count), 32'd0);
    do_fetch(0, 1'b0, 0, 0, 1'b0);
    repeat (3) tick();
    check("post_reset_count", 32'(fetch_count), 32'd1);
    check("final_queue", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
